// File: rtl/stencil_stream_ctrl.sv
// Sequencer for a line-buffer + stencil-kernel stage: counts pixels, drives the
// shared pipeline advance enable and carries window-valid/last tags to the kernel tail.
module stencil_stream_ctrl #(
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int STENCIL_W = 2,
  parameter int PIPE_LAT  = 5,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             lb_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] COL_FIRST_VLD = CNT_W'(STENCIL_W - 1);
  localparam logic [CNT_W-1:0] COL_LAST      = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST      = CNT_W'(IMG_H - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic [PIPE_LAT-1:0] tag_q, tag_d;
  logic [PIPE_LAT-1:0] last_q, last_d;

  logic stall;
  logic accept;
  logic ins_tag;
  logic ins_last;
  logic last_pix;

  // Tail of the tag pipe lines up with the kernel result leaving the adders.
  assign out_valid = tag_q[PIPE_LAT-1];
  assign out_last  = last_q[PIPE_LAT-1] & tag_q[PIPE_LAT-1];
  assign stall     = out_valid & ~out_ready;

  assign col  = col_q;
  assign row  = row_q;
  assign busy = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  assign ins_tag  = (col_q >= COL_FIRST_VLD);
  assign last_pix = (col_q == COL_LAST) & (row_q == ROW_LAST);
  assign ins_last = ins_tag & last_pix;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    tag_d    = tag_q;
    last_d   = last_q;
    in_ready = 1'b0;
    lb_en    = 1'b0;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          tag_d   = '0;
          last_d  = '0;
        end
      end

      S_RUN: begin
        in_ready = ~stall;
        accept   = in_valid & ~stall;
        lb_en    = accept;
        if (accept) begin
          tag_d  = PIPE_LAT'({tag_q, ins_tag});
          last_d = PIPE_LAT'({last_q, ins_last});
          if (last_pix) begin
            col_d   = '0;
            row_d   = '0;
            state_d = S_DRAIN;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        // Flush with empty tags until the final beat leaves the tail.
        lb_en = ~stall;
        if (~stall) begin
          tag_d  = PIPE_LAT'({tag_q, 1'b0});
          last_d = PIPE_LAT'({last_q, 1'b0});
        end
        if (out_valid & out_last & out_ready) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      tag_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_stencil_stream_ctrl.sv
// Directed bench for stencil_stream_ctrl: a 4x2 frame instance and a 2x1 frame
// instance, each run recorded cycle-by-cycle into bit masks and compared to hand timelines.
module tb_stencil_stream_ctrl;

  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, in_valid, out_ready, sel;

  logic ir0, lb0, ov0, ol0, bz0, dn0;
  logic ir1, lb1, ov1, ol1, bz1, dn1;
  logic [CW-1:0] col0, row0, col1, row1;

  logic s_ir, s_lb, s_ov, s_ol, s_bz, s_dn;
  logic [CW-1:0] s_col, s_row;

  stencil_stream_ctrl #(
    .IMG_W(4), .IMG_H(2), .STENCIL_W(2), .PIPE_LAT(3), .CNT_W(CW)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(ir0), .lb_en(lb0), .out_valid(ov0), .out_ready(out_ready),
    .out_last(ol0), .col(col0), .row(row0), .busy(bz0), .done(dn0)
  );

  stencil_stream_ctrl #(
    .IMG_W(2), .IMG_H(1), .STENCIL_W(2), .PIPE_LAT(3), .CNT_W(CW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(ir1), .lb_en(lb1), .out_valid(ov1), .out_ready(out_ready),
    .out_last(ol1), .col(col1), .row(row1), .busy(bz1), .done(dn1)
  );

  assign s_ir  = sel ? ir1  : ir0;
  assign s_lb  = sel ? lb1  : lb0;
  assign s_ov  = sel ? ov1  : ov0;
  assign s_ol  = sel ? ol1  : ol0;
  assign s_bz  = sel ? bz1  : bz0;
  assign s_dn  = sel ? dn1  : dn0;
  assign s_col = sel ? col1 : col0;
  assign s_row = sel ? row1 : row0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ir_m, lb_m, ov_m, ol_m, dn_m, bz_m;
  int beats, adv, done_cnt;
  logic [CW-1:0] col_a [0:31];
  logic [CW-1:0] row_a [0:31];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle 0 carries start; inputs change 1ns after each rising edge, sampled on the falling edge.
  task automatic run_frame(input bit gaps, input bit bp, input bit ign);
    ir_m = '0; lb_m = '0; ov_m = '0; ol_m = '0; dn_m = '0; bz_m = '0;
    beats = 0; adv = 0; done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      start     = (c == 0) || (ign && (c == 3 || c == 10));
      in_valid  = gaps ? (c % 2 == 1) : 1'b1;
      out_ready = bp ? !(c >= 5 && c <= 7) : 1'b1;
      #4;
      ir_m[c] = s_ir;
      lb_m[c] = s_lb;
      ov_m[c] = s_ov;
      ol_m[c] = s_ol;
      dn_m[c] = s_dn;
      bz_m[c] = s_bz;
      col_a[c] = s_col;
      row_a[c] = s_row;
      if (s_ov && out_ready) beats++;
      if (s_ov && out_ready && s_lb) adv++;
      if (s_dn) done_cnt++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_outputs", {26'd0, s_ir, s_lb, s_ov, s_ol, s_bz, s_dn}, 32'd0);
    check("rst_col_row", {s_col, s_row}, 32'd0);
    do_reset();

    // Nominal 4x2 frame
    run_frame(1'b0, 1'b0, 1'b0);
    check("nom_in_ready", ir_m, 32'h0000_01FE);
    check("nom_lb_en",    lb_m, 32'h0000_0FFE);
    check("nom_out_valid", ov_m, 32'h0000_0EE0);
    check("nom_out_last", ol_m, 32'h0000_0800);
    check("nom_done",     dn_m, 32'h0000_1000);
    check("nom_busy",     bz_m, 32'h0000_0FFE);
    check("nom_beats",    beats, 32'd6);

    // Downstream stall cycles 5..7
    do_reset();
    run_frame(1'b0, 1'b1, 1'b0);
    check("bp_in_ready",  ir_m, 32'h0000_0F1E);
    check("bp_lb_en",     lb_m, 32'h0000_7F1E);
    check("bp_out_valid", ov_m, 32'h0000_77E0);
    check("bp_out_last",  ol_m, 32'h0000_4000);
    check("bp_done",      dn_m, 32'h0000_8000);
    check("bp_beats",     beats, 32'd6);

    // Upstream gaps: valid only on odd cycles
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0);
    check("gap_lb_en_run", lb_m & 32'h0000_FFFF, 32'h0000_AAAA);
    check("gap_col_c3",   col_a[3], 32'd1);
    check("gap_col_c4",   col_a[4], 32'd2);
    check("gap_outputs",  adv, 32'd6);
    check("gap_out_last", ol_m, 32'h0004_0000);
    check("gap_done",     dn_m, 32'h0008_0000);

    // start pulsed in RUN (cycle 3) and DRAIN (cycle 10)
    do_reset();
    run_frame(1'b0, 1'b0, 1'b1);
    check("ign_col_c4",   col_a[4], 32'd3);
    check("ign_row_c6",   row_a[6], 32'd1);
    check("ign_out_valid", ov_m, 32'h0000_0EE0);
    check("ign_done",     dn_m, 32'h0000_1000);
    check("ign_done_cnt", done_cnt, 32'd1);

    // Asynchronous reset mid-RUN with a valid tag at the tail
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk);
      #1;
      start = (c == 0);
      in_valid = 1'b1;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("pre_rst_ov", s_ov, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {26'd0, s_ir, s_lb, s_ov, s_ol, s_bz, s_dn}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_edge_outs", {26'd0, s_ov, s_bz, s_ir, s_lb, s_ol, s_dn}, 32'd0);
    check("rst_edge_cnt",  {s_col, s_row}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0);
    check("post_rst_out_valid", ov_m, 32'h0000_0EE0);
    check("post_rst_done",      dn_m, 32'h0000_1000);

    // Single-row 2x1 frame on the second instance
    sel = 1'b1;
    do_reset();
    run_frame(1'b0, 1'b0, 1'b0);
    check("row1_in_ready",  ir_m, 32'h0000_0006);
    check("row1_out_valid", ov_m, 32'h0000_0020);
    check("row1_out_last",  ol_m, 32'h0000_0020);
    check("row1_done",      dn_m, 32'h0000_0040);
    check("row1_beats",     beats, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stencil_stream_ctrl.md
Name: stencil_stream_ctrl

Overview:
- Sequencer for one line-buffer + stencil-kernel stage: LB shift registers, then pipelined ADD kernels.
- Runs one frame per `start`:
  - counts input pixels (column/row);
  - drives a single pipeline advance enable (`lb_en`) to the LB and kernel registers;
  - tags each pixel with window validity and delays the tag by the pipeline latency to produce `out_valid`/`out_last`;
  - drains the pipeline after the last pixel, then pulses `done`.
- Provides valid/ready backpressure on both sides.

Parameters:
- IMG_W, 64, pixels per row (≥ STENCIL_W).
- IMG_H, 64, rows per frame (≥1).
- STENCIL_W, 2, horizontal stencil width; first STENCIL_W-1 columns of each row produce no output.
- PIPE_LAT, 5, lb_en-advances from input acceptance to the kernel result for that window (LB input reg + shift + kernel adders); ≥1.
- CNT_W, 16, width of column/row counters.

Ports:
- clk, in, 1, clock; all state updates on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begins a frame; honoured only in IDLE.
- in_valid, in, 1, upstream pixel valid.
- in_ready, out, 1, controller accepts pixel this cycle.
- lb_en, out, 1, advance enable for LB shift registers and kernel pipeline registers.
- out_valid, out, 1, kernel output at pipeline tail is a valid stencil result.
- out_ready, in, 1, downstream accepts output.
- out_last, out, 1, qualifies the final output beat of the frame.
- col, out, CNT_W, column index of the next pixel to accept.
- row, out, CNT_W, row index of the next pixel to accept.
- busy, out, 1, high in RUN and DRAIN.
- done, out, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (rst_n=0, async, any state):
  - state=IDLE; col=row=0; tag and last pipes cleared.
  - All outputs 0: in_ready, lb_en, out_valid, out_last, busy, done.
- stall = out_valid & ~out_ready.
- in_ready = (state==RUN) & ~stall. Accept = in_valid & in_ready.
- lb_en:
  - RUN: lb_en = Accept.
  - DRAIN: lb_en = ~stall.
  - IDLE/DONE: lb_en = 0.
- Tag pipe (PIPE_LAT entries) and last pipe:
  - shift only when lb_en=1.
  - Entry inserted on Accept: tag = (col ≥ STENCIL_W-1); last = tag & (col==IMG_W-1) & (row==IMG_H-1).
  - Entry inserted on DRAIN advance: tag=0, last=0.
- out_valid = tail tag; out_last = tail last & tail tag.
  - When lb_en=0, the tail holds, so out_valid/data stay stable while stalled.
- Output beat occurs when out_valid & out_ready. Since lb_en=0 when RUN has no input, a valid output remains presented until input resumes or DRAIN.
- Counters update on Accept only:
  - col increments; at col==IMG_W-1, col wraps to 0 and row increments.
  - Accepting pixel (IMG_W-1, IMG_H-1): col=row=0, state→DRAIN.
- FSM:
  - IDLE: start → RUN; col/row/pipes cleared on entry.
  - RUN: → DRAIN after accepting the last pixel.
  - DRAIN: → DONE when the out_last beat completes (out_valid & out_last & out_ready).
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- Outputs per frame = IMG_H × (IMG_W - STENCIL_W + 1), exactly; no output for warm-up columns.
- Row boundary: the first STENCIL_W-1 pixels of each row still shift through the LB (lb_en=1) but carry tag=0.
- Simultaneous Accept and stall is impossible, because in_ready is gated by stall.
- busy = (state==RUN) | (state==DRAIN).

Test Plan:
- Reset/idle: rst_n low mid-RUN with a valid tag in the pipe → next clk edge sees out_valid=0, busy=0, col=row=0, state IDLE; start afterward runs a full frame normally.
- Nominal frame: IMG_W=4, IMG_H=2, STENCIL_W=2, PIPE_LAT=3, in_valid=1, out_ready=1, start at cycle 0.
  - Accepts cycles 1..8.
  - out_valid at cycles 5,6,7, then 9,10,11 (6 beats); bubbles at 4 and 8 are from col0 tags.
  - out_last at 11; done at 12.
- Downstream backpressure: nominal frame with out_ready=0 for cycles 5..7 → out_valid held at 5..7, in_ready=0 and lb_en=0 during 5..7, and the beat count still equals 6.
- Upstream gaps: in_valid toggled 1,0,1,0… → lb_en equals Accept; col advances only on accepted cycles; output count 6; the last output still flagged.
- Start ignored: start pulsed during RUN and DRAIN → no counter reset and exactly one done pulse.
- Single-row edge: IMG_W=2, IMG_H=1, STENCIL_W=2 → exactly one output, which has out_last=1, then done.
